// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sized FIFO: reset polarity, count width
// and the non-power-of-2 pointer wrap.
package fifo_pkg;

    localparam logic RST_ACTIVE = 1'b0;

    function automatic int calc_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointers wrap at depth-1 so they never reach depth, even when depth is not a power of 2.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctl.sv
// Pointer, occupancy and flag control for fifo_sized_cnt; no data path.
// All flags are registered from next_count so they never glitch.
module fifo_ptr_ctl
    import fifo_pkg::*;
#(
    parameter int depth     = 4,
    parameter int af_thresh = depth - 1,
    parameter int guarded   = 1,
    localparam int cw       = calc_cw(depth),
    localparam int pw       = $clog2(depth)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ENQ,
    input  logic          DEQ,
    input  logic          CLR,
    output logic          we,
    output logic [pw-1:0] head,
    output logic [pw-1:0] tail,
    output logic [cw-1:0] COUNT,
    output logic          FULL_N,
    output logic          EMPTY_N,
    output logic          ALMOST_FULL,
    output logic          ERR_OVF,
    output logic          ERR_UDF
);

    // Handshake: ENQ transfers when FULL_N=1 (or, unguarded, when full with a
    // same-cycle DEQ); DEQ transfers when EMPTY_N=1. Anything else is flagged, not executed.
    logic          enq_ok;
    logic          deq_ok;
    logic [cw-1:0] count_nxt;
    logic [pw-1:0] head_nxt;
    logic [pw-1:0] tail_nxt;

    always_comb begin
        enq_ok    = ENQ && (FULL_N || ((guarded == 0) && DEQ && EMPTY_N));
        deq_ok    = DEQ && EMPTY_N;
        count_nxt = COUNT;
        if (enq_ok && !deq_ok) begin
            count_nxt = COUNT + 1'b1;
        end else if (deq_ok && !enq_ok) begin
            count_nxt = COUNT - 1'b1;
        end
        head_nxt = deq_ok ? pw'(ptr_inc(32'(head), depth)) : head;
        tail_nxt = enq_ok ? pw'(ptr_inc(32'(tail), depth)) : tail;
        we       = enq_ok && (RST != RST_ACTIVE) && !CLR;
    end

    always_ff @(posedge CLK) begin
        if (RST == RST_ACTIVE || CLR) begin
            head        <= '0;
            tail        <= '0;
            COUNT       <= '0;
            FULL_N      <= 1'b1;
            EMPTY_N     <= 1'b0;
            ALMOST_FULL <= 1'b0;
            ERR_OVF     <= 1'b0;
            ERR_UDF     <= 1'b0;
        end else begin
            head        <= head_nxt;
            tail        <= tail_nxt;
            COUNT       <= count_nxt;
            FULL_N      <= (count_nxt != cw'(depth));
            EMPTY_N     <= (count_nxt != '0);
            ALMOST_FULL <= (count_nxt >= cw'(af_thresh));
            ERR_OVF     <= ERR_OVF | (ENQ & ~enq_ok);
            ERR_UDF     <= ERR_UDF | (DEQ & ~EMPTY_N);
        end
    end

`ifdef FIFO_SIM_CHECKS
    always @(posedge CLK) begin
        if (RST != RST_ACTIVE && !CLR) begin
            if (ENQ && !enq_ok) $warning("fifo_ptr_ctl: illegal ENQ while full");
            if (DEQ && !EMPTY_N) $warning("fifo_ptr_ctl: illegal DEQ while empty");
        end
    end
`endif

endmodule

// File: rtl/fifo_sized_cnt.sv
// Parametrised-depth synchronous FIFO with occupancy count, almost-full and
// sticky error flags. Holds the storage; control lives in fifo_ptr_ctl.
module fifo_sized_cnt
    import fifo_pkg::*;
#(
    parameter int width     = 1,
    parameter int depth     = 4,
    parameter int af_thresh = depth - 1,
    parameter int guarded   = 1,
    localparam int cw       = calc_cw(depth)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [width-1:0] D_IN,
    input  logic             ENQ,
    input  logic             DEQ,
    input  logic             CLR,
    output logic [width-1:0] D_OUT,
    output logic             FULL_N,
    output logic             EMPTY_N,
    output logic             ALMOST_FULL,
    output logic [cw-1:0]    COUNT,
    output logic             ERR_OVF,
    output logic             ERR_UDF
);

    localparam int pw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic             we;
    logic [pw-1:0]    head;
    logic [pw-1:0]    tail;

    fifo_ptr_ctl #(
        .depth     (depth),
        .af_thresh (af_thresh),
        .guarded   (guarded)
    ) u_ctl (
        .CLK         (CLK),
        .RST         (RST),
        .ENQ         (ENQ),
        .DEQ         (DEQ),
        .CLR         (CLR),
        .we          (we),
        .head        (head),
        .tail        (tail),
        .COUNT       (COUNT),
        .FULL_N      (FULL_N),
        .EMPTY_N     (EMPTY_N),
        .ALMOST_FULL (ALMOST_FULL),
        .ERR_OVF     (ERR_OVF),
        .ERR_UDF     (ERR_UDF)
    );

    // Storage is deliberately not reset; D_OUT is meaningful only while EMPTY_N=1.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[tail] <= D_IN;
        end
    end

    assign D_OUT = mem[head];

endmodule

// File: tb/tb_fifo_sized_cnt.sv
// Bench for fifo_sized_cnt: three configurations (guarded d4, unguarded d4,
// guarded d3) driven in lockstep and compared against a queue-based model.
module tb_fifo_sized_cnt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s [3];
    logic       clr_s [3];
    logic       enq_s [3];
    logic       deq_s [3];
    logic [7:0] din_s [3];
    logic [7:0] dout_s [3];
    logic       full_n_s [3];
    logic       empty_n_s [3];
    logic       af_s [3];
    logic       ovf_s [3];
    logic       udf_s [3];
    logic [2:0] cnt_s [3];
    logic [1:0] cnt_d3;

    assign cnt_s[2] = {1'b0, cnt_d3};

    int         m_depth [3];
    int         m_af [3];
    int         m_guard [3];
    logic [7:0] exp_q [3][$];
    bit         exp_ovf [3];
    bit         exp_udf [3];
    int         n_vec = 0;
    int         n_err = 0;

    fifo_sized_cnt #(.width(8), .depth(4), .af_thresh(3), .guarded(1)) dut_g (
        .CLK(clk), .RST(rst_s[0]), .D_IN(din_s[0]), .ENQ(enq_s[0]), .DEQ(deq_s[0]),
        .CLR(clr_s[0]), .D_OUT(dout_s[0]), .FULL_N(full_n_s[0]), .EMPTY_N(empty_n_s[0]),
        .ALMOST_FULL(af_s[0]), .COUNT(cnt_s[0]), .ERR_OVF(ovf_s[0]), .ERR_UDF(udf_s[0])
    );

    fifo_sized_cnt #(.width(8), .depth(4), .af_thresh(3), .guarded(0)) dut_u (
        .CLK(clk), .RST(rst_s[1]), .D_IN(din_s[1]), .ENQ(enq_s[1]), .DEQ(deq_s[1]),
        .CLR(clr_s[1]), .D_OUT(dout_s[1]), .FULL_N(full_n_s[1]), .EMPTY_N(empty_n_s[1]),
        .ALMOST_FULL(af_s[1]), .COUNT(cnt_s[1]), .ERR_OVF(ovf_s[1]), .ERR_UDF(udf_s[1])
    );

    fifo_sized_cnt #(.width(8), .depth(3), .af_thresh(2), .guarded(1)) dut_d3 (
        .CLK(clk), .RST(rst_s[2]), .D_IN(din_s[2]), .ENQ(enq_s[2]), .DEQ(deq_s[2]),
        .CLR(clr_s[2]), .D_OUT(dout_s[2]), .FULL_N(full_n_s[2]), .EMPTY_N(empty_n_s[2]),
        .ALMOST_FULL(af_s[2]), .COUNT(cnt_d3), .ERR_OVF(ovf_s[2]), .ERR_UDF(udf_s[2])
    );

    task automatic check_eq(input string tag, input int k, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", tag, k, obs, exp, $time);
        end
    endtask

    // Reference behaviour: a queue of stored bytes plus the two sticky error bits.
    task automatic model_step(input int k);
        int sz;
        bit enq_ok;
        bit deq_ok;
        if (!rst_s[k] || clr_s[k]) begin
            exp_q[k].delete();
            exp_ovf[k] = 1'b0;
            exp_udf[k] = 1'b0;
            return;
        end
        sz     = exp_q[k].size();
        deq_ok = deq_s[k] && (sz > 0);
        enq_ok = enq_s[k] && ((sz < m_depth[k]) || ((m_guard[k] == 0) && deq_s[k]));
        if (enq_s[k] && !enq_ok) exp_ovf[k] = 1'b1;
        if (deq_s[k] && sz == 0) exp_udf[k] = 1'b1;
        if (deq_ok) void'(exp_q[k].pop_front());
        if (enq_ok) exp_q[k].push_back(din_s[k]);
    endtask

    task automatic check_dut(input int k);
        int sz;
        sz = exp_q[k].size();
        check_eq("COUNT", k, 32'(cnt_s[k]), 32'(sz));
        check_eq("FULL_N", k, 32'(full_n_s[k]), 32'(sz != m_depth[k]));
        check_eq("EMPTY_N", k, 32'(empty_n_s[k]), 32'(sz != 0));
        check_eq("ALMOST_FULL", k, 32'(af_s[k]), 32'(sz >= m_af[k]));
        check_eq("ERR_OVF", k, 32'(ovf_s[k]), 32'(exp_ovf[k]));
        check_eq("ERR_UDF", k, 32'(udf_s[k]), 32'(exp_udf[k]));
        if (sz > 0) check_eq("D_OUT", k, 32'(dout_s[k]), 32'(exp_q[k][0]));
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 3; k++) begin
            rst_s[k] = 1'b1;
            clr_s[k] = 1'b0;
            enq_s[k] = 1'b0;
            deq_s[k] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        for (int k = 0; k < 3; k++) check_dut(k);
        check_eq("PTR_RANGE", 2, 32'(dut_d3.head < 2'd3 && dut_d3.tail < 2'd3), 32'd1);
        idle_inputs();
    endtask

    task automatic push(input int k, input logic [7:0] d);
        enq_s[k] = 1'b1;
        din_s[k] = d;
        tick();
    endtask

    task automatic pop(input int k);
        deq_s[k] = 1'b1;
        tick();
    endtask

    task automatic push_pop(input int k, input logic [7:0] d);
        enq_s[k] = 1'b1;
        deq_s[k] = 1'b1;
        din_s[k] = d;
        tick();
    endtask

    task automatic clear(input int k);
        clr_s[k] = 1'b1;
        tick();
    endtask

    initial begin
        m_depth[0] = 4; m_af[0] = 3; m_guard[0] = 1;
        m_depth[1] = 4; m_af[1] = 3; m_guard[1] = 0;
        m_depth[2] = 3; m_af[2] = 2; m_guard[2] = 1;
        idle_inputs();
        for (int k = 0; k < 3; k++) din_s[k] = 8'h00;

        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
            tick();
        end

        // Fill and drain in order.
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
        check_eq("AF_AT_3", 0, 32'(af_s[0]), 32'd1);
        push(0, 8'h44);
        check_eq("FULL_AT_4", 0, 32'(full_n_s[0]), 32'd0);
        check_eq("HEAD_11", 0, 32'(dout_s[0]), 32'h11);
        for (int i = 0; i < 4; i++) pop(0);
        check_eq("EMPTY_AFTER_DRAIN", 0, 32'(empty_n_s[0]), 32'd0);

        // Non-power-of-2 depth, interleaved traffic keeping occupancy <= 2.
        for (int i = 1; i <= 10; i++) begin
            enq_s[2] = 1'b1;
            din_s[2] = 8'(i);
            deq_s[2] = (exp_q[2].size() >= 2);
            tick();
        end
        while (exp_q[2].size() > 0) pop(2);

        // Full with ENQ+DEQ: unguarded keeps both, guarded drops the enqueue.
        for (int i = 1; i <= 4; i++) push(1, 8'(i));
        push_pop(1, 8'h55);
        check_eq("UNG_COUNT", 1, 32'(cnt_s[1]), 32'd4);
        check_eq("UNG_OVF", 1, 32'(ovf_s[1]), 32'd0);
        for (int i = 0; i < 4; i++) pop(1);
        for (int i = 1; i <= 4; i++) push(0, 8'(i));
        push_pop(0, 8'h55);
        check_eq("GRD_COUNT", 0, 32'(cnt_s[0]), 32'd3);
        check_eq("GRD_OVF", 0, 32'(ovf_s[0]), 32'd1);
        for (int i = 0; i < 3; i++) pop(0);
        clear(0);

        // Empty with ENQ+DEQ: no bypass, underflow flagged, CLR clears it.
        push_pop(0, 8'hAA);
        check_eq("EMPTY_ED_DOUT", 0, 32'(dout_s[0]), 32'hAA);
        check_eq("EMPTY_ED_UDF", 0, 32'(udf_s[0]), 32'd1);
        clear(0);
        check_eq("CLR_UDF", 0, 32'(udf_s[0]), 32'd0);

        // Reset mid-operation discards a concurrent ENQ.
        push(0, 8'h01); push(0, 8'h02);
        rst_s[0] = 1'b0; enq_s[0] = 1'b1; din_s[0] = 8'h99;
        tick();
        check_eq("RST_COUNT", 0, 32'(cnt_s[0]), 32'd0);

        // CLR beats ENQ; the next ENQ appears one cycle later.
        push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
        clr_s[0] = 1'b1; enq_s[0] = 1'b1; din_s[0] = 8'h33;
        tick();
        check_eq("CLR_ENQ_COUNT", 0, 32'(cnt_s[0]), 32'd0);
        push(0, 8'h7E);
        check_eq("POST_CLR_DOUT", 0, 32'(dout_s[0]), 32'h7E);

        // Random traffic on all three configurations.
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 3; k++) begin
                rst_s[k] = ($urandom_range(0, 63) != 0);
                clr_s[k] = ($urandom_range(0, 31) == 0);
                enq_s[k] = ($urandom_range(0, 99) < 55);
                deq_s[k] = ($urandom_range(0, 99) < 45);
                din_s[k] = 8'($urandom);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
